// File: rtl/jtframe_scal_mon.sv
// jtframe_scal_mon
// Monitor for the Pocket scaler video stream. Measures total and active
// geometry per frame and counts frames. It flags timing changes and declares
// the timing stable after a run of identical frames. It can also produce an
// optional per-frame pixel signature.
//
// Optional feature macro: JTFRAME_SCAL_SIG_EN
//   defined     -> running 32-bit pixel signature latched into frame_sig
//   not defined -> no signature logic, frame_sig is constant 0
//
// Ports
//   clk        pixel clock, one pixel slot per cycle
//   rst        synchronous reset, active high
//   vs, hs     vertical / horizontal sync, active high (rising edge is the event)
//   de, skip   data enable; a slot counts as a pixel when de & ~skip
//   vid        pixel word (DW bits)
//   htotal     clocks between consecutive hs rises (last closed line)
//   hactive    pixels on the last line that had any pixel
//   vtotal     hs rises counted in the frame
//   vactive    lines holding at least one pixel
//   frame_cnt  completed frames, wraps
//   frame_sig  per-frame pixel signature
//   stable     geometry unchanged for STABLE_FRAMES frames
//   changed    one-cycle pulse when the new geometry differs from the last one
//   ovf        sticky, some counter saturated
//
// The stream is a plain sampled bus with no valid/ready handshake: every
// cycle carries one slot, and de/skip qualify it as a pixel.
module jtframe_scal_mon #(
  parameter int DW            = 24,
  parameter int HW            = 12,
  parameter int VW            = 10,
  parameter int FW            = 16,
  parameter int STABLE_FRAMES = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vs,
  input  logic          hs,
  input  logic          de,
  input  logic          skip,
  input  logic [DW-1:0] vid,
  output logic [HW-1:0] htotal,
  output logic [HW-1:0] hactive,
  output logic [VW-1:0] vtotal,
  output logic [VW-1:0] vactive,
  output logic [FW-1:0] frame_cnt,
  output logic [31:0]   frame_sig,
  output logic          stable,
  output logic          changed,
  output logic          ovf
);

  localparam logic [HW-1:0] H_ONE   = HW'(1);
  localparam logic [VW-1:0] V_ONE   = VW'(1);
  localparam logic [FW-1:0] F_ONE   = FW'(1);
  localparam logic [7:0]    RUN_MAX = 8'(STABLE_FRAMES);

  logic          vs_q, hs_q, de_q, skip_q;
  logic          vs_d, hs_d;
  logic          vs_rise, hs_rise, pix;

  logic [HW-1:0] hcnt, pcnt, line_len_q, hact_q;
  logic [VW-1:0] lcnt, acnt;
  logic          armed;
  logic [7:0]    run_q;

  logic [HW-1:0] hcnt_n, pcnt_n, line_len_n, hact_n;
  logic [VW-1:0] lcnt_n, acnt_n;
  logic [7:0]    run_n;
  logic          line_has_pix, sat_hit, geo_same;

  // Input register stage plus one extra stage of vs/hs for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q   <= 1'b0;
      hs_q   <= 1'b0;
      de_q   <= 1'b0;
      skip_q <= 1'b0;
      vs_d   <= 1'b0;
      hs_d   <= 1'b0;
    end else begin
      vs_q   <= vs;
      hs_q   <= hs;
      de_q   <= de;
      skip_q <= skip;
      vs_d   <= vs_q;
      hs_d   <= hs_q;
    end
  end

  assign vs_rise = vs_q & ~vs_d;
  assign hs_rise = hs_q & ~hs_d;
  assign pix     = de_q & ~skip_q;

  // Next-state values with the line close already applied. A frame close
  // in the same cycle as an hs rise uses these values, so the closing line
  // is counted into the frame.
  always_comb begin
    line_has_pix = hs_rise && (pcnt != '0);

    hcnt_n     = hs_rise ? H_ONE : ((&hcnt) ? hcnt : hcnt + H_ONE);
    line_len_n = hs_rise ? hcnt : line_len_q;
    hact_n     = line_has_pix ? pcnt : hact_q;
    lcnt_n     = (hs_rise && !(&lcnt)) ? lcnt + V_ONE : lcnt;
    acnt_n     = (line_has_pix && !(&acnt)) ? acnt + V_ONE : acnt;

    // A pixel in the hs-rise slot belongs to the line that starts there.
    if (hs_rise)
      pcnt_n = pix ? H_ONE : '0;
    else if (pix && !(&pcnt))
      pcnt_n = pcnt + H_ONE;
    else
      pcnt_n = pcnt;

    sat_hit = (!hs_rise && (&hcnt)) ||
              (!hs_rise && pix && (&pcnt)) ||
              (hs_rise && (&lcnt)) ||
              (line_has_pix && (&acnt));

    geo_same = (line_len_n == htotal) && (hact_n == hactive) &&
               (lcnt_n == vtotal) && (acnt_n == vactive);

    if (!geo_same)
      run_n = 8'd0;
    else if (run_q == RUN_MAX)
      run_n = run_q;
    else
      run_n = run_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt       <= '0;
      pcnt       <= '0;
      line_len_q <= '0;
      hact_q     <= '0;
      lcnt       <= '0;
      acnt       <= '0;
      armed      <= 1'b0;
      run_q      <= 8'd0;
      htotal     <= '0;
      hactive    <= '0;
      vtotal     <= '0;
      vactive    <= '0;
      frame_cnt  <= '0;
      stable     <= 1'b0;
      changed    <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      changed    <= 1'b0;
      hcnt       <= hcnt_n;
      line_len_q <= line_len_n;
      hact_q     <= hact_n;
      if (sat_hit) ovf <= 1'b1;

      if (vs_rise) begin
        lcnt <= '0;
        acnt <= '0;
        pcnt <= '0;
        if (!armed) begin
          // First vs after reset: the partial frame before it is discarded.
          armed <= 1'b1;
        end else begin
          htotal    <= line_len_n;
          hactive   <= hact_n;
          vtotal    <= lcnt_n;
          vactive   <= acnt_n;
          frame_cnt <= frame_cnt + F_ONE;
          run_q     <= run_n;
          stable    <= (run_n == RUN_MAX);
          changed   <= !geo_same;
        end
      end else begin
        lcnt <= lcnt_n;
        acnt <= acnt_n;
        pcnt <= pcnt_n;
      end
    end
  end

`ifdef JTFRAME_SCAL_SIG_EN
  logic [DW-1:0] vid_q;
  logic [31:0]   sig, vid32;

  // Zero-extends narrow pixels, truncates wide ones.
  assign vid32 = 32'(vid_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      vid_q     <= '0;
      sig       <= 32'd0;
      frame_sig <= 32'd0;
    end else begin
      vid_q <= vid;
      if (vs_rise) begin
        if (armed) frame_sig <= sig;
        sig <= 32'd0;
      end else if (pix) begin
        sig <= {sig[30:0], sig[31]} ^ vid32;
      end
    end
  end
`else
  logic unused_vid;
  assign unused_vid = ^vid;
  assign frame_sig  = 32'd0;
`endif

endmodule

// File: tb/tb_jtframe_scal_mon.sv
module tb_jtframe_scal_mon;
  localparam int SF = 4;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vs = 1'b0, hs = 1'b0, de = 1'b0, skip = 1'b0;
  logic [23:0] vid = 24'd0;

  logic [11:0] htotal, hactive;
  logic [9:0]  vtotal, vactive;
  logic [15:0] frame_cnt;
  logic [31:0] frame_sig;
  logic        stable, changed, ovf;

  logic [7:0]  htotal8, hactive8;
  logic [9:0]  vtotal8, vactive8;
  logic [15:0] frame_cnt8;
  logic [31:0] frame_sig8;
  logic        stable8, changed8, ovf8;

  always #5 clk = ~clk;

  jtframe_scal_mon dut (
    .clk(clk), .rst(rst), .vs(vs), .hs(hs), .de(de), .skip(skip), .vid(vid),
    .htotal(htotal), .hactive(hactive), .vtotal(vtotal), .vactive(vactive),
    .frame_cnt(frame_cnt), .frame_sig(frame_sig), .stable(stable),
    .changed(changed), .ovf(ovf)
  );

  // Narrow horizontal counters: long lines must saturate.
  jtframe_scal_mon #(.HW(8)) dut8 (
    .clk(clk), .rst(rst), .vs(vs), .hs(hs), .de(de), .skip(skip), .vid(vid),
    .htotal(htotal8), .hactive(hactive8), .vtotal(vtotal8), .vactive(vactive8),
    .frame_cnt(frame_cnt8), .frame_sig(frame_sig8), .stable(stable8),
    .changed(changed8), .ovf(ovf8)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int chg_cnt = 0;
  int last_chg = 0;

  always @(negedge clk) if (changed === 1'b1) chg_cnt++;

  // ---------------- reference model ----------------
  typedef struct {
    int len; int n; int a0; int a1; int de;
    bit skip; bit simul; bit cvid;
  } geom_t;

  geom_t       prev_g, g_base;
  bit          m_armed;
  int          m_run;
  logic [11:0] e_h, e_ha;
  logic [9:0]  e_v, e_va;
  logic [15:0] e_fc;
  logic [31:0] e_sig, model_sig;
  logic        e_stable;
  int          e_chg;

  function automatic geom_t mk(input int len, input int n, input int a0, input int a1,
                               input int dl, input bit sk, input bit sim, input bit cv);
    geom_t g;
    g.len = len; g.n = n; g.a0 = a0; g.a1 = a1; g.de = dl;
    g.skip = sk; g.simul = sim; g.cvid = cv;
    return g;
  endfunction

  task automatic model_reset();
    m_armed = 0; m_run = 0;
    e_h = 0; e_ha = 0; e_v = 0; e_va = 0; e_fc = 0; e_sig = 0;
    e_stable = 0; e_chg = 0; model_sig = 0;
  endtask

  // Expected result of the vs that closes the frame described by prev_g.
  task automatic model_close();
    logic [11:0] h, ha;
    logic [9:0]  v, va;
    bit same;
    if (!m_armed) begin
      m_armed = 1;
      e_chg = 0;
    end else begin
      h  = 12'(prev_g.len);
      ha = 12'(prev_g.skip ? (prev_g.de + 1) / 2 : prev_g.de);
      v  = 10'(prev_g.n);
      va = 10'(prev_g.a1 - prev_g.a0 + 1);
      same = (h == e_h) && (ha == e_ha) && (v == e_v) && (va == e_va);
      e_chg = same ? 0 : 1;
      m_run = same ? ((m_run < SF) ? m_run + 1 : SF) : 0;
      e_stable = (m_run == SF);
      e_h = h; e_ha = ha; e_v = v; e_va = va;
      e_fc = e_fc + 16'd1;
`ifdef JTFRAME_SCAL_SIG_EN
      e_sig = model_sig;
`endif
    end
    model_sig = 0;
  endtask

  // ---------------- drivers ----------------
  task automatic drive_line(input geom_t g, input int l);
    for (int c = 0; c < g.len; c++) begin
      @(negedge clk);
      hs   = (c < 3);
      vs   = (l == 0) && (g.simul ? (c < 4) : (c >= 10 && c < 14));
      de   = (l >= g.a0) && (l <= g.a1) && (c >= 4) && (c < 4 + g.de);
      skip = de && g.skip && (((c - 4) % 2) == 1);
      vid  = g.cvid ? 24'h000001 : 24'($urandom);
      if (de && !skip) model_sig = {model_sig[30:0], model_sig[31]} ^ {8'h00, vid};
    end
  endtask

  // Line 0 carries the vs that closes the previously driven frame.
  task automatic drive_frame_part(input geom_t g, input int lines);
    int c0;
    c0 = chg_cnt;
    model_close();
    prev_g = g;
    for (int l = 0; l < lines; l++) drive_line(g, l);
    last_chg = chg_cnt - c0;
  endtask

  task automatic drive_frame(input geom_t g);
    drive_frame_part(g, g.n);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (htotal !== 12'd0) begin n_fail++; $display("FAIL reset_htotal got=%0d exp=0", htotal); end
    n_tests++; if (hactive !== 12'd0) begin n_fail++; $display("FAIL reset_hactive got=%0d exp=0", hactive); end
    n_tests++; if (vtotal !== 10'd0) begin n_fail++; $display("FAIL reset_vtotal got=%0d exp=0", vtotal); end
    n_tests++; if (vactive !== 10'd0) begin n_fail++; $display("FAIL reset_vactive got=%0d exp=0", vactive); end
    n_tests++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
    n_tests++; if (frame_sig !== 32'd0) begin n_fail++; $display("FAIL reset_frame_sig got=%h exp=0", frame_sig); end
    n_tests++; if ({stable, changed, ovf, ovf8} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got=%b exp=0000", {stable, changed, ovf, ovf8}); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_geometry();
    g_base = mk(40, 20, 2, 17, 30, 0, 0, 0);
    drive_frame(g_base);  // arms only
    drive_frame(g_base);  // closes the discarded-free first frame
    n_tests++; if (htotal !== e_h) begin n_fail++; $display("FAIL geo_htotal got=%0d exp=%0d", htotal, e_h); end
    n_tests++; if (hactive !== e_ha) begin n_fail++; $display("FAIL geo_hactive got=%0d exp=%0d", hactive, e_ha); end
    n_tests++; if (vtotal !== e_v) begin n_fail++; $display("FAIL geo_vtotal got=%0d exp=%0d", vtotal, e_v); end
    n_tests++; if (vactive !== e_va) begin n_fail++; $display("FAIL geo_vactive got=%0d exp=%0d", vactive, e_va); end
    n_tests++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL geo_frame_cnt1 got=%0d exp=1", frame_cnt); end
    n_tests++; if (last_chg !== 1) begin n_fail++; $display("FAIL geo_changed1 pulses=%0d exp=1", last_chg); end
    drive_frame(g_base);
    n_tests++; if (last_chg !== 0) begin n_fail++; $display("FAIL geo_changed2 pulses=%0d exp=0", last_chg); end
    n_tests++; if (frame_cnt !== 16'd2) begin n_fail++; $display("FAIL geo_frame_cnt2 got=%0d exp=2", frame_cnt); end
  endtask

  task automatic test_stable();
    for (int i = 0; i < 4; i++) begin
      drive_frame(g_base);
      n_tests++; if (stable !== e_stable) begin n_fail++; $display("FAIL stable_run%0d got=%b exp=%b", i, stable, e_stable); end
    end
    n_tests++; if (stable !== 1'b1) begin n_fail++; $display("FAIL stable_final got=%b exp=1", stable); end
  endtask

  task automatic test_change();
    geom_t g2;
    g2 = g_base; g2.de = 24;
    drive_frame(g2);
    drive_frame(g2);
    n_tests++; if (last_chg !== 1) begin n_fail++; $display("FAIL change_pulse pulses=%0d exp=1", last_chg); end
    n_tests++; if (stable !== 1'b0) begin n_fail++; $display("FAIL change_stable got=%b exp=0", stable); end
    n_tests++; if (hactive !== 12'd24) begin n_fail++; $display("FAIL change_hactive got=%0d exp=24", hactive); end
    for (int i = 0; i < 5; i++) begin
      drive_frame(g2);
      n_tests++; if (stable !== e_stable) begin n_fail++; $display("FAIL change_restable%0d got=%b exp=%b", i, stable, e_stable); end
    end
    n_tests++; if (stable !== 1'b1) begin n_fail++; $display("FAIL change_stable_back got=%b exp=1", stable); end
  endtask

  task automatic test_skip_simul();
    geom_t g3;
    g3 = g_base; g3.skip = 1; g3.simul = 1; g3.de = 30;
    for (int i = 0; i < 3; i++) begin
      drive_frame(g3);
      n_tests++; if (hactive !== e_ha) begin n_fail++; $display("FAIL skip_hactive%0d got=%0d exp=%0d", i, hactive, e_ha); end
      n_tests++; if (vtotal !== e_v) begin n_fail++; $display("FAIL simul_vtotal%0d got=%0d exp=%0d", i, vtotal, e_v); end
      n_tests++; if (last_chg !== e_chg) begin n_fail++; $display("FAIL skip_changed%0d pulses=%0d exp=%0d", i, last_chg, e_chg); end
    end
    n_tests++; if (hactive !== 12'd15) begin n_fail++; $display("FAIL skip_hactive_half got=%0d exp=15", hactive); end
  endtask

  task automatic test_sig();
    geom_t gs;
    logic [31:0] lit;
`ifdef JTFRAME_SCAL_SIG_EN
    lit = 32'h00000003;
`else
    lit = 32'h0;
`endif
    gs = mk(24, 6, 2, 2, 2, 0, 0, 1);
    drive_frame(gs);
    drive_frame(g_base);
    n_tests++; if (frame_sig !== lit) begin n_fail++; $display("FAIL sig_const got=%h exp=%h", frame_sig, lit); end
    drive_frame(g_base);
    n_tests++; if (frame_sig !== e_sig) begin n_fail++; $display("FAIL sig_random got=%h exp=%h", frame_sig, e_sig); end
  endtask

  task automatic test_random();
    geom_t g;
    int a0;
    g = g_base;
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        g.len = $urandom_range(24, 48);
        g.n   = $urandom_range(6, 14);
        a0    = $urandom_range(1, 3);
        g.a0  = a0;
        g.a1  = $urandom_range(a0, g.n - 1);
        g.de  = $urandom_range(1, g.len - 8);
        g.skip = 1'($urandom_range(0, 1));
        g.simul = 1'($urandom_range(0, 1));
        g.cvid = 0;
      end
      drive_frame(g);
      n_tests++; if (htotal !== e_h) begin n_fail++; $display("FAIL rnd%0d_htotal got=%0d exp=%0d", i, htotal, e_h); end
      n_tests++; if (hactive !== e_ha) begin n_fail++; $display("FAIL rnd%0d_hactive got=%0d exp=%0d", i, hactive, e_ha); end
      n_tests++; if (vtotal !== e_v) begin n_fail++; $display("FAIL rnd%0d_vtotal got=%0d exp=%0d", i, vtotal, e_v); end
      n_tests++; if (vactive !== e_va) begin n_fail++; $display("FAIL rnd%0d_vactive got=%0d exp=%0d", i, vactive, e_va); end
      n_tests++; if (frame_cnt !== e_fc) begin n_fail++; $display("FAIL rnd%0d_frame_cnt got=%0d exp=%0d", i, frame_cnt, e_fc); end
      n_tests++; if (frame_sig !== e_sig) begin n_fail++; $display("FAIL rnd%0d_sig got=%h exp=%h", i, frame_sig, e_sig); end
      n_tests++; if (stable !== e_stable) begin n_fail++; $display("FAIL rnd%0d_stable got=%b exp=%b", i, stable, e_stable); end
      n_tests++; if (last_chg !== e_chg) begin n_fail++; $display("FAIL rnd%0d_changed pulses=%0d exp=%0d", i, last_chg, e_chg); end
    end
  endtask

  task automatic test_ovf();
    geom_t gl;
    gl = mk(300, 4, 1, 2, 20, 0, 0, 0);
    drive_frame(gl);
    drive_frame(g_base);
    n_tests++; if (htotal8 !== 8'hFF) begin n_fail++; $display("FAIL ovf_htotal8 got=%h exp=ff", htotal8); end
    n_tests++; if (ovf8 !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b exp=1", ovf8); end
    n_tests++; if (htotal !== 12'd300) begin n_fail++; $display("FAIL ovf_htotal_wide got=%0d exp=300", htotal); end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_wide_clear got=%b exp=0", ovf); end
    drive_frame(g_base);
    n_tests++; if (htotal8 !== 8'(g_base.len)) begin n_fail++; $display("FAIL ovf_htotal8_back got=%0d exp=%0d", htotal8, g_base.len); end
    n_tests++; if (ovf8 !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", ovf8); end
  endtask

  task automatic test_reset_mid();
    drive_frame(g_base);
    drive_frame_part(g_base, 5);
    @(negedge clk);
    rst = 1'b1; hs = 1'b0; vs = 1'b0; de = 1'b0; skip = 1'b0;
    @(negedge clk);
    n_tests++; if ({htotal, hactive} !== 24'd0) begin n_fail++; $display("FAIL mid_rst_h got=%0d/%0d exp=0/0", htotal, hactive); end
    n_tests++; if ({vtotal, vactive} !== 20'd0) begin n_fail++; $display("FAIL mid_rst_v got=%0d/%0d exp=0/0", vtotal, vactive); end
    n_tests++; if ({frame_cnt, frame_sig} !== 48'd0) begin n_fail++; $display("FAIL mid_rst_fc got=%0d/%h exp=0/0", frame_cnt, frame_sig); end
    n_tests++; if ({stable, changed, ovf, ovf8} !== 4'b0) begin n_fail++; $display("FAIL mid_rst_flags got=%b exp=0000", {stable, changed, ovf, ovf8}); end
    rst = 1'b0;
    model_reset();
    drive_frame(g_base);  // arms only
    n_tests++; if (frame_cnt !== 16'd0 || htotal !== 12'd0) begin n_fail++; $display("FAIL mid_arm got=%0d/%0d exp=0/0", frame_cnt, htotal); end
    n_tests++; if (last_chg !== 0) begin n_fail++; $display("FAIL mid_arm_changed pulses=%0d exp=0", last_chg); end
    drive_frame(g_base);
    n_tests++; if (htotal !== 12'(g_base.len)) begin n_fail++; $display("FAIL mid_htotal got=%0d exp=%0d", htotal, g_base.len); end
    n_tests++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL mid_frame_cnt got=%0d exp=1", frame_cnt); end
    n_tests++; if (last_chg !== 1) begin n_fail++; $display("FAIL mid_changed pulses=%0d exp=1", last_chg); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_reset();
    prev_g = mk(24, 6, 1, 1, 1, 0, 0, 0);
    test_reset();
    test_geometry();
    test_stable();
    test_change();
    test_skip_simul();
    test_sig();
    test_random();
    test_ovf();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
